matmul_arbiter: RTL
===================

MATMUL_ARBITER -- requirements
Module: matmul_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64, is the maximum number of cycles in WAIT before a job is aborted (range 2..65535).
REQ-002 Clock  input  1  single system clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of Clock.
REQ-004 req0_valid/req1_valid  input  1  requester N presents a job.
REQ-005 req0_A, req0_B, req1_A, req1_B  input  72  3x3 matrices of 8-bit elements, same packing as the engine.
REQ-006 req0_ready/req1_ready  output  1  the job is accepted on a cycle where valid and ready are both high.
REQ-007 rsp0_valid/rsp1_valid  output  1  a result is available for requester N.
REQ-008 rsp0_C/rsp1_C  output  72  result matrix.
REQ-009 rsp0_err/rsp1_err  output  1  high with rsp_valid when the job timed out.
REQ-010 rsp0_ready/rsp1_ready  input  1  requester N consumes the result.
REQ-011 eng_Enable  output  1  drives the Enable input of matrix_multiplication.
REQ-012 eng_A, eng_B  output  72  operands to the engine; registered.
REQ-013 eng_C  input  72  engine result.
REQ-014 eng_done  input  1  engine completion.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 grant_id  output  1  index of the requester owning the current or last job.
REQ-017 timeout  output  1  one-cycle pulse when a job is aborted.

Function
REQ-018 The FSM SHALL have the states IDLE, WAIT, RESP and DRAIN, one per cycle, with no other reachable states.
REQ-019 IDLE: the arbiter SHALL assert reqN_ready only for the arbitration winner; the winner is the only valid requester, or, if both are valid, the one not equal to last_grant (round-robin).
REQ-020 reqN_ready SHALL be low outside IDLE and low in IDLE when no requester is valid; ready may depend on valid, but never the reverse.
REQ-021 On acceptance in cycle T, the arbiter SHALL latch A/B into eng_A/eng_B, set grant_id and last_grant to the winner, and enter WAIT.
REQ-022 At T+1 eng_Enable SHALL be high; it SHALL stay high throughout WAIT and be low in every other state.
REQ-023 WAIT: the first cycle eng_done=1 is sampled, the arbiter SHALL capture eng_C into rspN_C with err=0 and enter RESP.
REQ-024 WAIT: a cycle counter SHALL start at 0 on entry and increment each cycle.
REQ-025 If the counter reaches TIMEOUT_CYCLES-1 with eng_done=0, the arbiter SHALL pulse timeout for 1 cycle, set rspN_C=0 and rspN_err=1, and enter RESP.
REQ-026 eng_done and timeout in the same cycle: done SHALL win (normal result, no timeout pulse).
REQ-027 RESP: rspN_valid SHALL be high for the granted N only; rspN_C and rspN_err SHALL stay stable until rspN_ready=1, after which rsp_valid drops and the FSM enters DRAIN.
REQ-028 DRAIN: the FSM SHALL stay while eng_done=1 and go to IDLE on the first cycle eng_done=0, so no job is issued while a stale done is asserted.
REQ-029 Minimum occupancy SHALL be accept(T), WAIT(T+1..), RESP >=1 cycle, DRAIN >=1 cycle; with an immediate done, back-to-back acceptances are at least 4 cycles apart.
REQ-030 Requests arriving outside IDLE SHALL be held by the requester and never dropped or reordered by the arbiter.
REQ-031 eng_C SHALL pass to rsp_C bit-for-bit; the arbiter performs no arithmetic on matrix data.

Reset
REQ-032 When reset=1 at a clock edge: state=IDLE, counter=0, last_grant=1 (so req0 wins the first contention).
REQ-033 When reset=1 at a clock edge, all outputs SHALL be 0: eng_Enable, eng_A/B, rsp*, req*_ready, busy, grant_id, timeout.
REQ-034 Reset asserted mid-job (any state) SHALL abort the job with no response; eng_Enable SHALL be low the cycle after reset is sampled.
REQ-035 After reset the first acceptance SHALL NOT occur until eng_done=0.

Verification
REQ-036 req0 only, A={1..9}, B={9..1}, real engine -> rsp0_valid, rsp0_C elements 30,24,18,84,69,54,138,114,90, rsp0_err=0, grant_id=0.
REQ-037 req0 and req1 valid on the same cycle after reset -> req0 served first, then req1; with both still valid, the order alternates 0,1,0,1 over 4 jobs.
REQ-038 Engine model that never raises done, TIMEOUT_CYCLES=8 -> timeout pulse exactly 8 cycles after Enable rose, rsp err=1, C=0, eng_Enable low the next cycle.
REQ-039 rsp0_ready held low for 20 cycles -> rsp0_valid/C stable for all 20, req1_ready stays low; after consumption, DRAIN waits for done=0.
REQ-040 Reset pulsed during WAIT -> eng_Enable=0 and busy=0 the next cycle, no rsp_valid; a new req0 then completes normally.
REQ-041 eng_done and counter expiry on the same cycle -> normal result, timeout never pulses.

Source files
------------

// File: rtl/matmul_arbiter_if.sv
// Bundle between two matrix requesters, the arbiter and the 3x3 matrix engine.
// Handshakes: a transfer happens on a rising edge where valid and ready are both high; ready may depend on valid, never the reverse.
interface matmul_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [71:0] req0_A;
  logic [71:0] req0_B;
  logic        req1_valid;
  logic        req1_ready;
  logic [71:0] req1_A;
  logic [71:0] req1_B;
  logic        rsp0_valid;
  logic        rsp0_ready;
  logic [71:0] rsp0_C;
  logic        rsp0_err;
  logic        rsp1_valid;
  logic        rsp1_ready;
  logic [71:0] rsp1_C;
  logic        rsp1_err;
  logic        eng_Enable;
  logic [71:0] eng_A;
  logic [71:0] eng_B;
  logic [71:0] eng_C;
  logic        eng_done;

  // arbiter side
  modport slave (
    input  req0_valid, req0_A, req0_B, req1_valid, req1_A, req1_B,
    input  rsp0_ready, rsp1_ready, eng_C, eng_done,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_C, rsp0_err, rsp1_valid, rsp1_C, rsp1_err,
    output eng_Enable, eng_A, eng_B
  );

  // requester / engine side
  modport master (
    output req0_valid, req0_A, req0_B, req1_valid, req1_A, req1_B,
    output rsp0_ready, rsp1_ready, eng_C, eng_done,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_C, rsp0_err, rsp1_valid, rsp1_C, rsp1_err,
    input  eng_Enable, eng_A, eng_B
  );
endinterface

// File: rtl/matmul_arbiter.sv
// Round-robin arbiter sharing one 3x3 matrix engine between two requesters,
// with a per-job timeout and a drain phase that waits out a stale engine done.
module matmul_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic              Clock,
  input  logic              reset,
  matmul_arbiter_if.slave   bus,
  output logic              busy,
  output logic              grant_id,
  output logic              timeout,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    RESP  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state;
  state_t      state_nxt;
  logic [15:0] cnt;
  logic        last_grant;
  logic [71:0] eng_a;
  logic [71:0] eng_b;
  logic [71:0] rsp0_c;
  logic [71:0] rsp1_c;
  logic        rsp0_e;
  logic        rsp1_e;

  logic        win_valid;
  logic        win_id;
  logic        accept;
  logic        done_hit;
  logic        expire;
  logic        rsp_take;

  // Acceptance is also held off while a stale done is still high (e.g. right after reset).
  always_comb begin
    win_valid = bus.req0_valid | bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid) win_id = ~last_grant;
    else                                  win_id = bus.req1_valid;
    accept   = (state == IDLE) && !reset && !bus.eng_done && win_valid;
    done_hit = (state == WAIT) && bus.eng_done;
    expire   = (state == WAIT) && !bus.eng_done && (cnt == CNT_LAST);
    rsp_take = (state == RESP) && (grant_id ? bus.rsp1_ready : bus.rsp0_ready);
  end

  always_ff @(posedge Clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = WAIT;
      WAIT:    if (done_hit || expire) state_nxt = RESP;
      RESP:    if (rsp_take) state_nxt = DRAIN;
      DRAIN:   if (!bus.eng_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.req0_ready = accept && !win_id;
    bus.req1_ready = accept && win_id;
    bus.eng_Enable = (state == WAIT);
    bus.rsp0_valid = (state == RESP) && !grant_id;
    bus.rsp1_valid = (state == RESP) && grant_id;
    busy           = (state != IDLE);
    state_dbg      = state;
  end

  assign bus.eng_A    = eng_a;
  assign bus.eng_B    = eng_b;
  assign bus.rsp0_C   = rsp0_c;
  assign bus.rsp1_C   = rsp1_c;
  assign bus.rsp0_err = rsp0_e;
  assign bus.rsp1_err = rsp1_e;

  // WAIT leaves at CNT_LAST at the latest, so cnt never wraps.
  always_ff @(posedge Clock) begin
    if (reset) begin
      cnt        <= '0;
      last_grant <= 1'b1;
      grant_id   <= 1'b0;
      timeout    <= 1'b0;
      eng_a      <= '0;
      eng_b      <= '0;
      rsp0_c     <= '0;
      rsp1_c     <= '0;
      rsp0_e     <= 1'b0;
      rsp1_e     <= 1'b0;
    end else begin
      timeout <= expire;
      if (accept) begin
        eng_a      <= win_id ? bus.req1_A : bus.req0_A;
        eng_b      <= win_id ? bus.req1_B : bus.req0_B;
        grant_id   <= win_id;
        last_grant <= win_id;
        cnt        <= '0;
      end else if (state == WAIT) begin
        cnt <= cnt + 16'd1;
      end
      if (done_hit) begin
        if (grant_id) begin
          rsp1_c <= bus.eng_C;
          rsp1_e <= 1'b0;
        end else begin
          rsp0_c <= bus.eng_C;
          rsp0_e <= 1'b0;
        end
      end else if (expire) begin
        if (grant_id) begin
          rsp1_c <= '0;
          rsp1_e <= 1'b1;
        end else begin
          rsp0_c <= '0;
          rsp0_e <= 1'b1;
        end
      end
    end
  end

endmodule
